// File: rtl/ram_stream_reader.sv
// Reads len words from a 1-cycle-latency RAM starting at base and streams them out.
// Optional out_last port enabled by defining RAM_STREAM_READER_LAST_EN.
module ram_stream_reader #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 8,
    parameter int AddressRange = 256
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base,
    input  logic [AddressWidth:0]   len,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    input  logic [DataWidth-1:0]    q0,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RAM_STREAM_READER_LAST_EN
    ,
    output logic                    out_last
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [AddressWidth:0] LenMax = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth:0] LenOne = (AddressWidth + 1)'(1);

    logic [1:0]              state;
    logic [AddressWidth-1:0] base_r;
    logic [AddressWidth:0]   len_r;
    logic [AddressWidth:0]   issue_cnt;
    logic                    inflight;
    logic                    done_r;

    logic [DataWidth-1:0]    mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;

    logic [1:0]              occ;
    logic                    issue;
    logic                    last_issue;
    logic                    xfer;
    logic                    push;
    logic                    pop;
    logic                    last_xfer;
    logic [AddressWidth:0]   len_eff;

    // Occupancy counts stored words plus the read whose data arrives this cycle.
    assign occ        = count + {1'b0, inflight};
    assign issue      = (state == RUN) && (occ < 2'd2);
    assign last_issue = issue && ((issue_cnt + LenOne) == len_r);
    assign xfer       = out_valid && out_ready;
    // Arriving data bypasses the FIFO when it is empty and taken immediately.
    assign push       = inflight && !(xfer && (count == 2'd0));
    assign pop        = xfer && (count != 2'd0);
    assign last_xfer  = (state == DRAIN) && xfer && (occ == 2'd1);
    assign len_eff    = (len > LenMax) ? LenMax : len;

    assign ce0       = issue;
    assign address0  = issue ? (base_r + issue_cnt[AddressWidth-1:0]) : '0;
    assign out_valid = (count != 2'd0) || inflight;
    assign out_data  = (count != 2'd0) ? mem[rd_ptr] : (inflight ? q0 : '0);
    assign busy      = (state != IDLE);
    assign done      = done_r;

`ifdef RAM_STREAM_READER_LAST_EN
    // In DRAIN every read is issued, so a single outstanding word is the final one.
    assign out_last = (state == DRAIN) && (occ == 2'd1);
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            base_r    <= '0;
            len_r     <= '0;
            issue_cnt <= '0;
            inflight  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            inflight <= issue;
            done_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_eff != '0) begin
                            base_r    <= base;
                            len_r     <= len_eff;
                            issue_cnt <= '0;
                            state     <= RUN;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + LenOne;
                    end
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_xfer) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= q0;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int AR = 256;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] address0;
    logic          ce0;
    logic [DW-1:0] q0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef RAM_STREAM_READER_LAST_EN
    logic          out_last;
`endif

    ram_stream_reader #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .address0  (address0),
        .ce0       (ce0),
        .q0        (q0),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RAM_STREAM_READER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    logic [DW-1:0] ram [AR];
    always @(posedge ap_clk) q0 <= ce0 ? ram[address0] : DW'($urandom());

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the words and addresses still owed by the accepted request.
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    bit            exp_busy = 1'b0;
    bit            exp_done = 1'b0;
    int            occ      = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data;

    int            xfer_cyc [$];
    logic [DW-1:0] xfer_dat [$];
    bit            xfer_last [$];
    int            ce_cyc   [$];
    logic [AW-1:0] seen_addr [$];
    int            done_cyc [$];
    int            busy_cnt = 0;

    task automatic clear_logs();
        xfer_cyc.delete(); xfer_dat.delete(); xfer_last.delete();
        ce_cyc.delete(); seen_addr.delete(); done_cyc.delete();
        busy_cnt = 0;
    endtask

    always @(negedge ap_clk) begin
        bit next_busy;
        bit next_done;
        if (ap_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ce0", ce0, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_address0", address0, 0);
            chk("rst_out_data", out_data, 0);
            exp_data.delete();
            exp_addr.delete();
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            occ        = 0;
            stall_prev = 1'b0;
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cnt++;
            next_busy = exp_busy;
            next_done = 1'b0;
            if (ce0) begin
                ce_cyc.push_back(cyc);
                seen_addr.push_back(address0);
                chk("occupancy_at_issue", occ < 2, 1);
                if (exp_addr.size() == 0) chk("ce0_spurious", ce0, 0);
                else chk("address0", address0, exp_addr.pop_front());
                occ++;
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
`ifdef RAM_STREAM_READER_LAST_EN
            chk("out_last", out_last, out_valid && (exp_data.size() == 1));
`endif
            if (out_valid) begin
                if (exp_data.size() == 0) begin
                    chk("valid_spurious", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_data[0]);
                    if (out_ready) begin
                        xfer_cyc.push_back(cyc);
                        xfer_dat.push_back(out_data);
`ifdef RAM_STREAM_READER_LAST_EN
                        xfer_last.push_back(out_last);
`else
                        xfer_last.push_back(1'b0);
`endif
                        void'(exp_data.pop_front());
                        occ--;
                        if (exp_data.size() == 0) begin
                            next_busy = 1'b0;
                            next_done = 1'b1;
                        end
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (start && !exp_busy) begin
                if (len == 0) begin
                    next_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        exp_addr.push_back(AW'((int'(base) + i) % AR));
                        exp_data.push_back(ram[(int'(base) + i) % AR]);
                    end
                    next_busy = 1'b1;
                end
            end
            exp_busy = next_busy;
            exp_done = next_done;
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic req(input logic [AW-1:0] b, input logic [AW:0] l, output int s);
        start = 1'b1;
        base  = b;
        len   = l;
        s     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle, input string tag);
        int n = 0;
        while ((exp_busy || exp_done) && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            step();
            n++;
        end
        chk({tag, "_timeout"}, exp_busy || exp_done, 0);
    endtask

    initial begin
        int s;
        int n;
        ap_rst = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        for (int i = 0; i < AR; i++) ram[i] = 32'hA000_0000 + DW'(i);
        step(); step();
        ap_rst = 1'b0;
        step();

        // base 0x10, len 4, ready held high
        out_ready = 1'b1;
        clear_logs();
        req(8'h10, 9'd4, s);
        wait_idle(50, 1'b0, "t1");
        chk("t1_nxfer", xfer_cyc.size(), 4);
        chk("t1_nce0", ce_cyc.size(), 4);
        if (xfer_cyc.size() == 4 && ce_cyc.size() == 4) begin
            chk("t1_first_valid_lat", xfer_cyc[0] - s, 2);
            chk("t1_last_xfer_lat", xfer_cyc[3] - s, 5);
            chk("t1_ce0_consecutive", ce_cyc[3] - ce_cyc[0], 3);
            chk("t1_addr0", seen_addr[0], 8'h10);
            chk("t1_addr3", seen_addr[3], 8'h13);
            chk("t1_word0", xfer_dat[0], 32'hA000_0010);
            chk("t1_word3", xfer_dat[3], 32'hA000_0013);
        end
        chk("t1_ndone", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t1_done_lat", done_cyc[0] - s, 6);

        // address wrap
        clear_logs();
        req(8'hFE, 9'd4, s);
        wait_idle(50, 1'b0, "t2");
        chk("t2_naddr", seen_addr.size(), 4);
        if (seen_addr.size() == 4) begin
            chk("t2_addr0", seen_addr[0], 8'hFE);
            chk("t2_addr1", seen_addr[1], 8'hFF);
            chk("t2_addr2", seen_addr[2], 8'h00);
            chk("t2_addr3", seen_addr[3], 8'h01);
        end

        // ready toggling every cycle
        clear_logs();
        req(8'h40, 9'd8, s);
        wait_idle(100, 1'b1, "t3");
        chk("t3_nxfer", xfer_dat.size(), 8);
        for (int i = 0; i < xfer_dat.size(); i++)
            chk("t3_word", xfer_dat[i], 32'hA000_0040 + DW'(i));
        out_ready = 1'b1;

        // zero-length request
        clear_logs();
        req(8'h20, 9'd0, s);
        wait_idle(10, 1'b0, "t4");
        step(); step();
        chk("t4_nce0", ce_cyc.size(), 0);
        chk("t4_busy_cycles", busy_cnt, 0);
        chk("t4_ndone", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t4_done_lat", done_cyc[0] - s, 1);

        // reset mid-transfer, then a fresh request
        clear_logs();
        req(8'h80, 9'd16, s);
        n = 0;
        while (xfer_cyc.size() < 3 && n < 50) begin step(); n++; end
        chk("t5_reach_word3", xfer_cyc.size() >= 3, 1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        clear_logs();
        step();
        req(8'h00, 9'd2, s);
        wait_idle(50, 1'b0, "t5");
        step(); step();
        chk("t5_nxfer", xfer_dat.size(), 2);
        if (xfer_dat.size() == 2) begin
            chk("t5_word0", xfer_dat[0], 32'hA000_0000);
            chk("t5_word1", xfer_dat[1], 32'hA000_0001);
            chk("t5_first_valid_lat", xfer_cyc[0] - s, 2);
        end

`ifdef RAM_STREAM_READER_LAST_EN
        clear_logs();
        req(8'h30, 9'd3, s);
        wait_idle(50, 1'b0, "t6");
        chk("t6_nxfer", xfer_last.size(), 3);
        if (xfer_last.size() == 3) begin
            chk("t6_last0", xfer_last[0], 0);
            chk("t6_last1", xfer_last[1], 0);
            chk("t6_last2", xfer_last[2], 1);
        end
`endif

        // randomized traffic, including ignored starts and occasional resets
        for (int i = 0; i < AR; i++) ram[i] = DW'($urandom());
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1499) == 0) begin
                start  = 1'b0;
                ap_rst = 1'b1;
                step();
                ap_rst = 1'b0;
            end else begin
                start = ($urandom_range(0, 11) == 0);
                base  = AW'($urandom());
                case ($urandom_range(0, 19))
                    0:       len = 9'd0;
                    1:       len = 9'd256;
                    default: len = 9'($urandom_range(1, 12));
                endcase
                step();
                start = 1'b0;
            end
        end
        out_ready = 1'b1;
        wait_idle(600, 1'b0, "rand_drain");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
